// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard/flush controller with stale-fetch drain FSM
// Optional perf counters: define PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int RAW   = 5,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           if_outstanding_i,
    input  logic           if_resp_valid_i,
    input  logic           ex_busy_i,
    input  logic           mem_busy_i,
    input  logic           id_rs1_ren_i,
    input  logic           id_rs2_ren_i,
    input  logic [RAW-1:0] id_rs1_i,
    input  logic [RAW-1:0] id_rs2_i,
    input  logic           ex_valid_i,
    input  logic           ex_load_i,
    input  logic [RAW-1:0] ex_rd_i,
    input  logic           ex_redirect_i,
    input  logic           mem_trap_i,
    output logic           pc_hold_o,
    output logic           pc_redirect_o,
    output logic           pc_sel_o,
    output logic           if_id_hold_o,
    output logic           id_ex_hold_o,
    output logic           ex_mem_hold_o,
    output logic           mem_wb_hold_o,
    output logic           if_id_clear_o,
    output logic           id_ex_clear_o,
    output logic           ex_mem_clear_o,
    output logic           mem_wb_clear_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_lu_stall_o,
    output logic [CNT_W-1:0] perf_flush_o
`endif
);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t state;
    logic   load_use;
    logic   redirect;
    logic   lu_active;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign load_use = ex_valid_i & ex_load_i & (ex_rd_i != '0) &
                      ((id_rs1_ren_i & (id_rs1_i == ex_rd_i)) |
                       (id_rs2_ren_i & (id_rs2_i == ex_rd_i)));

    always_comb begin
        pc_hold_o      = 1'b0;
        pc_redirect_o  = 1'b0;
        pc_sel_o       = 1'b0;
        if_id_hold_o   = 1'b0;
        id_ex_hold_o   = 1'b0;
        ex_mem_hold_o  = 1'b0;
        mem_wb_hold_o  = 1'b0;
        if_id_clear_o  = 1'b0;
        id_ex_clear_o  = 1'b0;
        ex_mem_clear_o = 1'b0;
        mem_wb_clear_o = 1'b0;
        redirect       = 1'b0;
        lu_active      = 1'b0;

        // Fixed priority: a stalled MEM freezes everything upstream, deferring traps/redirects
        if (mem_busy_i) begin
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_hold_o   = 1'b1;
            ex_mem_hold_o  = 1'b1;
            mem_wb_clear_o = 1'b1;
        end else if (mem_trap_i) begin
            redirect       = 1'b1;
            pc_sel_o       = 1'b1;
            if_id_clear_o  = 1'b1;
            id_ex_clear_o  = 1'b1;
            ex_mem_clear_o = 1'b1;
        end else if (ex_busy_i) begin
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_hold_o   = 1'b1;
            ex_mem_clear_o = 1'b1;
        end else if (ex_redirect_i) begin
            redirect       = 1'b1;
            if_id_clear_o  = 1'b1;
            id_ex_clear_o  = 1'b1;
        end else if (load_use) begin
            lu_active      = 1'b1;
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_clear_o  = 1'b1;
        end else if (state == RUN && !if_resp_valid_i) begin
            if_id_clear_o  = 1'b1;
        end

        pc_redirect_o = redirect;

        // A stale fetch is in flight: drop whatever lands in IF/ID until it returns
        if (state == DRAIN) begin
            if_id_clear_o = 1'b1;
            if_id_hold_o  = 1'b0;
            if (!redirect) begin
                pc_hold_o = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_hold_o      = 1'b0;
            pc_redirect_o  = 1'b0;
            pc_sel_o       = 1'b0;
            if_id_hold_o   = 1'b0;
            id_ex_hold_o   = 1'b0;
            ex_mem_hold_o  = 1'b0;
            mem_wb_hold_o  = 1'b0;
            if_id_clear_o  = 1'b0;
            id_ex_clear_o  = 1'b0;
            ex_mem_clear_o = 1'b0;
            mem_wb_clear_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (redirect && if_outstanding_i && !if_resp_valid_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (if_resp_valid_i) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_stall_o <= '0;
            perf_flush_o    <= '0;
        end else begin
            if (lu_active && perf_lu_stall_o != '1) begin
                perf_lu_stall_o <= perf_lu_stall_o + 1'b1;
            end
            if (redirect && perf_flush_o != '1) begin
                perf_flush_o <= perf_flush_o + 1'b1;
            end
        end
    end
`else
    logic unused_lu;
    assign unused_lu = lu_active;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard/flush controller for the 5-stage rvcpu pipeline (IF→ID→EX→MEM→WB).
- Drives the hold/clear control pair of each of the four inter-stage pipeline registers (if_id, id_ex, ex_mem, mem_wb), plus PC hold/redirect strobes to the fetch unit.
- Resolves memory, multicycle-EX, load-use, branch-redirect and trap events by fixed priority.
- Tracks a stale in-flight fetch after any redirect, via a small FSM.

Parameters:
- RAW, 5, register-address width.
- CNT_W, 32, perf counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_outstanding_i  in  1  fetch request in flight
- if_resp_valid_i  in  1  fetch response returns this cycle
- ex_busy_i  in  1  multicycle op (mul/div) in EX not done
- mem_busy_i  in  1  LSU access in MEM not done
- id_rs1_ren_i  in  1  ID reads rs1
- id_rs2_ren_i  in  1  ID reads rs2
- id_rs1_i  in  RAW  ID rs1 address
- id_rs2_i  in  RAW  ID rs2 address
- ex_valid_i  in  1  EX stage holds valid instr
- ex_load_i  in  1  EX instr is a load
- ex_rd_i  in  RAW  EX destination reg
- ex_redirect_i  in  1  EX resolved taken branch/jump mispredict
- mem_trap_i  in  1  exception/interrupt taken at MEM commit
- pc_hold_o  out  1  fetch must not advance PC
- pc_redirect_o  out  1  load new PC this cycle
- pc_sel_o  out  1  0 = EX target, 1 = trap vector
- if_id_hold_o, id_ex_hold_o, ex_mem_hold_o, mem_wb_hold_o  out  1 each
- if_id_clear_o, id_ex_clear_o, ex_mem_clear_o, mem_wb_clear_o  out  1 each

Behaviour:
- All outputs are combinational from inputs + FSM state (zero latency). Only the FSM (and perf counters) are registered.
- During reset assertion, state=RUN and all outputs are 0.
- Priority, highest first. Exactly one row applies per cycle; all other holds/clears are 0.
  1. mem_busy_i: pc_hold, if_id/id_ex/ex_mem hold; mem_wb_clear. Pending redirect/trap deferred (held stages keep the inputs asserted).
  2. mem_trap_i: pc_redirect=1, pc_sel=1; clear if_id, id_ex, ex_mem.
  3. ex_busy_i: pc_hold, if_id/id_ex hold; ex_mem_clear. ex_redirect_i is ignored while ex_busy_i.
  4. ex_redirect_i: pc_redirect=1, pc_sel=0; clear if_id, id_ex.
  5. load-use: ex_valid_i & ex_load_i & ex_rd_i!=0 & ((id_rs1_ren_i & id_rs1_i==ex_rd_i) | (id_rs2_ren_i & id_rs2_i==ex_rd_i)). Then pc_hold, if_id_hold; id_ex_clear.
  6. else (RUN, if_resp_valid_i=0): if_id_clear=1 (fetch bubble); no holds.
- pc_sel_o = 0 whenever pc_redirect_o = 0.
- Hold and clear are never both 1 for the same register.
- FSM states RUN, DRAIN:
  - RUN→DRAIN: redirect issued (row 2 or 4) while if_outstanding_i=1 and if_resp_valid_i=0.
  - DRAIN: if_id_clear forced 1 (overrides if_id_hold) so the stale response is discarded. pc_hold forced 1 unless a new redirect is issued.
  - DRAIN→RUN: the cycle if_resp_valid_i=1.
  - A redirect in DRAIN stays in DRAIN (same single outstanding fetch). A redirect coinciding with the response → RUN.
- Redirect in RUN with if_resp_valid_i=1 the same cycle: the response is dropped via the if_id clear; stay RUN.
- Async reset mid-DRAIN → RUN immediately; the stale response is the fetch unit's responsibility after reset.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_lu_stall_o [CNT_W], counting load-use cycles (row 5 active), and perf_flush_o [CNT_W], counting redirect cycles (rows 2, 4).
  - Both counters saturate at all-ones and reset to 0 asynchronously.
- Undefined: the ports and counters are absent. Control behaviour is identical.

Test Plan:
- Load-use: ex_valid=1, ex_load=1, ex_rd=5, id_rs2_ren=1, id_rs2=5 → pc_hold=1, if_id_hold=1, id_ex_clear=1. With ex_rd=0 → no stall.
- Mem stall with pending trap: mem_busy=1, mem_trap=1 for 3 cycles → only row-1 outputs, pc_redirect=0. mem_busy falls → one cycle pc_redirect=1, pc_sel=1, if_id/id_ex/ex_mem_clear=1.
- EX redirect with outstanding fetch: ex_redirect=1, if_outstanding=1 → redirect, state DRAIN. Next 2 cycles if_id_clear=1, pc_hold=1. if_resp_valid=1 → RUN next cycle.
- ex_busy=1 & ex_redirect=1 → no redirect; ex_mem_clear=1. ex_busy falls → pc_redirect=1, pc_sel=0.
- Trap and redirect same cycle → pc_sel=1, ex_mem_clear=1.
- Reset asserted asynchronously in DRAIN → all outputs 0 without a clock edge. After release, state RUN.
- PIPE_HAZARD_PERF_EN: 4 load-use cycles, 2 redirects → perf_lu_stall=4, perf_flush=2. Preload at saturation → holds all-ones.
